// File: rtl/bcd_pkg.sv
// Shared definitions for the serial BCD adder: FSM state encoding and
// decimal-adjust constants.
package bcd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [4:0] BCD_MAX  = 5'd9;
   localparam logic [4:0] BCD_CORR = 5'd6;

endpackage

// File: rtl/bcd_digit_add.sv
// Single BCD digit adder with decimal adjust.
// Purely combinational; the controller time-shares one instance across all digits.
module bcd_digit_add
   import bcd_pkg::*;
(
   input  logic [3:0] da,
   input  logic [3:0] db,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co
);

   logic [4:0] w_t;
   logic [4:0] w_adj;

   assign w_t   = {1'b0, da} + {1'b0, db} + {4'b0, ci};
   assign w_adj = w_t + BCD_CORR;

   // Inputs above 9 still go through the same adjust, so the result is defined.
   always_comb begin
      s  = w_t[3:0];
      co = 1'b0;
      if (w_t > BCD_MAX) begin
         s  = w_adj[3:0];
         co = 1'b1;
      end
   end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial BCD adder: latches operands on start, adds one digit per cycle
// from digit 0 upward, then pulses done for one cycle.
module bcd_serial_add_ctrl
   import bcd_pkg::*;
#(
   parameter int NDIG = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [4*NDIG-1:0]   a,
   input  logic [4*NDIG-1:0]   b,
   input  logic                cin,
   output logic                busy,
   output logic                done,
   output logic [4*NDIG-1:0]   sum,
   output logic                cout,
   output logic                err
);

   localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [IW-1:0] LAST = IW'(NDIG - 1);

   state_t              r_state;
   state_t              w_next;
   logic [IW-1:0]       r_idx;
   logic [4*NDIG-1:0]   r_a;
   logic [4*NDIG-1:0]   r_b;
   logic                r_c;
   logic [4*NDIG-1:0]   r_sum;
   logic                r_cout;
   logic                r_err;

   logic                w_load;
   logic                w_step;
   logic                w_last;
   logic [3:0]          w_da;
   logic [3:0]          w_db;
   logic [3:0]          w_s;
   logic                w_co;
   logic                w_dig_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (start)  w_next = ST_RUN;
         ST_RUN:  if (w_last) w_next = ST_DONE;
         ST_DONE:             w_next = ST_IDLE;
         default:             w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      busy   = (r_state != ST_IDLE);
      done   = (r_state == ST_DONE);
      w_load = (r_state == ST_IDLE) && start;
      w_step = (r_state == ST_RUN);
   end

   assign w_last    = (r_idx == LAST);
   assign w_da      = r_a[{r_idx, 2'b00} +: 4];
   assign w_db      = r_b[{r_idx, 2'b00} +: 4];
   assign w_dig_err = ({1'b0, w_da} > BCD_MAX) || ({1'b0, w_db} > BCD_MAX);

   bcd_digit_add u_dig (
      .da (w_da),
      .db (w_db),
      .ci (r_c),
      .s  (w_s),
      .co (w_co)
   );

   // Operand copies make the a/b/cin pins don't-care once the op is accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx  <= '0;
         r_a    <= '0;
         r_b    <= '0;
         r_c    <= 1'b0;
         r_sum  <= '0;
         r_cout <= 1'b0;
         r_err  <= 1'b0;
      end else if (w_load) begin
         r_idx  <= '0;
         r_a    <= a;
         r_b    <= b;
         r_c    <= cin;
         r_sum  <= '0;
         r_cout <= 1'b0;
         r_err  <= 1'b0;
      end else if (w_step) begin
         r_idx                     <= r_idx + 1'b1;
         r_sum[{r_idx, 2'b00} +: 4] <= w_s;
         r_c                       <= w_co;
         if (w_dig_err) r_err  <= 1'b1;
         if (w_last)    r_cout <= w_co;
      end
   end

   assign sum  = r_sum;
   assign cout = r_cout;
   assign err  = r_err;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Directed bench for bcd_serial_add_ctrl (NDIG=4) with hand-computed results.
module tb_bcd_serial_add_ctrl;

   localparam int NDIG = 4;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [15:0]   a;
   logic [15:0]   b;
   logic          cin;
   logic          busy;
   logic          done;
   logic [15:0]   sum;
   logic          cout;
   logic          err;

   int total;
   int bad;

   bcd_serial_add_ctrl #(.NDIG(NDIG)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout),
      .err   (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One operation; rep>0 re-asserts start (with other operands) on that RUN cycle.
   task automatic run_op(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                         input logic ic, input logic [15:0] es, input logic ec,
                         input logic ee, input int rep);
      int cyc;
      int bcnt;
      bit got_done;
      @(negedge clk);
      start = 1'b1; a = ia; b = ib; cin = ic;
      @(posedge clk);
      #1;
      start = 1'b0; a = 16'hffff; b = 16'hffff; cin = 1'b1;
      cyc = 0; bcnt = 0; got_done = 0;
      while (!got_done && cyc < 20) begin
         @(negedge clk);
         cyc++;
         if (busy) bcnt++;
         if (done) got_done = 1;
         start = (cyc == rep);
         if (cyc == rep) begin a = 16'h1111; b = 16'h1111; end
      end
      start = 1'b0;
      chk({tag, "_done_seen"}, got_done, 1'b1);
      chk({tag, "_lat"}, cyc, NDIG + 1);
      chk({tag, "_busy_cyc"}, bcnt, NDIG + 1);
      chk({tag, "_sum"}, sum, es);
      chk({tag, "_cout"}, cout, ec);
      chk({tag, "_err"}, err, ee);
      @(negedge clk);
      chk({tag, "_idle_busy"}, busy, 1'b0);
      chk({tag, "_idle_done"}, done, 1'b0);
      @(negedge clk);
      chk({tag, "_hold_sum"}, sum, es);
      chk({tag, "_hold_flags"}, {cout, err, done}, {ec, ee, 1'b0});
   endtask

   initial begin
      total = 0; bad = 0;
      rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_outs", {busy, done, sum, cout, err}, '0);
      rst_n = 1'b1;

      run_op("add1234", 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 0);
      run_op("add9999", 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
      run_op("cin_only", 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, 0);
      run_op("bad_dig", 16'h000a, 16'h0000, 1'b0, 16'h0010, 1'b0, 1'b1, 0);
      run_op("err_clr", 16'h0045, 16'h0055, 1'b0, 16'h0100, 1'b0, 1'b0, 0);
      run_op("repulse", 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 2);

      // Reset in the 3rd RUN cycle, after two digits have been written.
      @(negedge clk);
      start = 1'b1; a = 16'h1234; b = 16'h5678; cin = 1'b0;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_outs", {busy, done, sum, cout, err}, '0);
      begin
         bit saw_done;
         saw_done = 0;
         repeat (3) begin
            @(negedge clk);
            if (done || busy) saw_done = 1;
         end
         chk("midrst_quiet", saw_done, 1'b0);
      end
      rst_n = 1'b1;
      run_op("after_rst", 16'h0500, 16'h0500, 1'b0, 16'h1000, 1'b0, 1'b0, 0);

      // Start held high: back-to-back ops, one idle cycle between them.
      @(negedge clk);
      start = 1'b1; a = 16'h1234; b = 16'h5678; cin = 1'b0;
      @(posedge clk);
      #1 a = 16'h0001; b = 16'h0002;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (c == 5) begin
            chk("b2b_done1", done, 1'b1);
            chk("b2b_sum1", sum, 16'h6912);
         end
         if (c == 6) chk("b2b_gap", {busy, done}, 2'b00);
         if (c == 7) begin
            chk("b2b_busy2", busy, 1'b1);
            start = 1'b0;
         end
         if (c == 10) chk("b2b_nodone", done, 1'b0);
         if (c == 11) begin
            chk("b2b_done2", done, 1'b1);
            chk("b2b_sum2", sum, 16'h0003);
         end
         if (c == 12) chk("b2b_end", busy, 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bcd_serial_add_ctrl.md
BCD_SERIAL_ADD_CTRL -- requirements
Module: bcd_serial_add_ctrl

Interface
REQ-001 Parameter NDIG, default 4: number of BCD digits per operand; legal range 1..16.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 a  input  4*NDIG  operand A; digit 0 is in bits [3:0].
REQ-006 b  input  4*NDIG  operand B, same packing as a.
REQ-007 cin  input  1  carry into digit 0.
REQ-008 busy  output  1  high whenever state is not IDLE.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 sum  output  4*NDIG  BCD result, same packing as a.
REQ-011 cout  output  1  decimal carry out of digit NDIG-1.
REQ-012 err  output  1  at least one operand digit exceeded 9 in the last operation.

Function
REQ-013 FSM states SHALL be IDLE, RUN and DONE.
REQ-014 IDLE with start=1 at an edge: latch a, b and cin; clear digit index, sum, cout and err; go to RUN.
REQ-015 RUN: each edge SHALL process the digit at the current index, write its sum digit and register its carry as the carry-in for the next digit.
REQ-016 RUN: the index SHALL increment on each edge; the edge that processes digit NDIG-1 SHALL load cout and go to DONE.
REQ-017 DONE: done=1 for exactly one cycle; the next edge SHALL return to IDLE.
REQ-018 Latency: done SHALL rise NDIG edges after the edge that sampled start; the block is occupied for NDIG+1 cycles in total.
REQ-019 Digit add: t = da + db + c (5 bits); if t > 9 then s = (t+6) mod 16 and carry = 1; otherwise s = t and carry = 0.
REQ-020 Any latched digit > 9 SHALL set err, which stays set until the next accepted start; the sum is still computed per REQ-019.
REQ-021 start while busy=1 SHALL be ignored; there is no queueing.
REQ-022 Operand inputs SHALL be don't-care after the start edge, because the latched copies are used.
REQ-023 sum, cout and err SHALL hold their values from DONE until the next accepted start.
REQ-024 start held high continuously SHALL begin a new operation on the first edge in IDLE after DONE.

Reset
REQ-025 rst_n=0 SHALL immediately force the state to IDLE, and busy, done, sum, cout, err and the index to 0, including mid-RUN.
REQ-026 A partial result SHALL NOT survive reset; operation resumes on the first start after rst_n deasserts.

Structure
REQ-027 A shared package bcd_pkg SHALL hold the state enum type, BCD_MAX=9 and BCD_CORR=6.
REQ-028 The digit arithmetic of REQ-019 SHALL be one combinational sub-module, bcd_digit_add (inputs da, db, ci; outputs s, co), instantiated once and time-shared across digits.

Verification
REQ-029 NDIG=4, a=1234, b=5678, cin=0, start pulse -> done 4 edges later; sum=6912, cout=0, err=0; busy high for 5 cycles.
REQ-030 a=9999, b=0001, cin=0 -> sum=0000, cout=1; a=0000, b=0000, cin=1 -> sum=0001, cout=0.
REQ-031 a digit 0 = 1010, b=0000 (the rest of a = 0), cin=0 -> err=1 at done; sum digit 0 = 0000 with its carry propagated, so sum=0010, cout=0.
REQ-032 start re-pulsed on the 2nd RUN cycle with different operands -> ignored; the result matches the first operands and there is a single done pulse.
REQ-033 rst_n pulsed low during the 3rd RUN cycle -> all outputs 0 at once, no done pulse; a following start with 0500+0500 gives sum=1000.
REQ-034 start held high through two operations -> back-to-back results; one IDLE cycle sits between the done pulse and the next busy assertion.
